// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies a debounced button into single/double click and long press pulses.
// Double-click detection (WAIT2/PRESS2) is compiled in only with BUTTON_EVENT_DCLICK_EN.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 16,
    parameter int DCLICK_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic debounced,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic held
);
    localparam int MAXC = LONG_CYCLES > DCLICK_CYCLES ? LONG_CYCLES : DCLICK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] LONG_LIM = CW'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_DCLICK_EN
    localparam logic [CW-1:0] DC_LIM = CW'(DCLICK_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD} state_t;
    logic dc_n;
`else
    typedef enum logic [2:0] {IDLE, PRESS1, LONG_HELD} state_t;
`endif
    state_t state, next;
    logic [CW-1:0] cnt;
    logic sc_n, lp_n, held_n, counted;

    always_comb begin
        next = state;
        sc_n = 1'b0;
        lp_n = 1'b0;
`ifdef BUTTON_EVENT_DCLICK_EN
        dc_n = 1'b0;
`endif
        case (state)
            IDLE: if (debounced) next = PRESS1;
            PRESS1:
                if (!debounced) begin
`ifdef BUTTON_EVENT_DCLICK_EN
                    next = WAIT2;
`else
                    next = IDLE;
                    sc_n = 1'b1;
`endif
                end else if (cnt == LONG_LIM) begin
                    next = LONG_HELD;
                    lp_n = 1'b1;
                end
`ifdef BUTTON_EVENT_DCLICK_EN
            WAIT2:
                if (debounced) next = PRESS2;
                else if (cnt == DC_LIM) begin
                    next = IDLE;
                    sc_n = 1'b1;
                end
            PRESS2:
                if (!debounced) begin
                    next = IDLE;
                    dc_n = 1'b1;
                end else if (cnt == LONG_LIM) begin
                    next = LONG_HELD;
                    lp_n = 1'b1;
                end
`endif
            LONG_HELD: if (!debounced) next = IDLE;
            default: next = IDLE;
        endcase
        held_n = next != IDLE;
`ifdef BUTTON_EVENT_DCLICK_EN
        held_n = held_n && next != WAIT2;
`endif
        // IDLE and LONG_HELD have no limit, so cnt is held at zero there
        counted = state != IDLE && state != LONG_HELD;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            single_click <= 1'b0;
            long_press   <= 1'b0;
            held         <= 1'b0;
        end else begin
            state        <= next;
            cnt          <= next != state ? '0 : (counted ? cnt + 1'b1 : cnt);
            single_click <= sc_n;
            long_press   <= lp_n;
            held         <= held_n;
        end
    end

`ifdef BUTTON_EVENT_DCLICK_EN
    always_ff @(posedge clock) double_click <= reset ? 1'b0 : dc_n;
`else
    assign double_click = 1'b0;
`endif
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed and random press patterns checked against a run-length model.
module tb_button_event_decoder;
    localparam int LONG = 16;
    localparam int DC   = 8;
`ifdef BUTTON_EVENT_DCLICK_EN
    localparam bit DEN = 1'b1;
`else
    localparam bit DEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic debounced = 1'b0;
    logic single_click, double_click, long_press, held;
    int tests = 0;
    int fails = 0;

    // Model state: gesture in progress, long hold reached, presses seen, current level and its run length
    bit in_g, long_m, lvl;
    int presses, run;
    bit e_sc, e_dc, e_lp, e_held;

    button_event_decoder #(.LONG_CYCLES(LONG), .DCLICK_CYCLES(DC)) dut (
        .clock(clk), .reset(reset), .debounced(debounced),
        .single_click(single_click), .double_click(double_click),
        .long_press(long_press), .held(held)
    );

    always #5 clk = ~clk;

    task automatic model(input logic d, input logic r);
        e_sc = 1'b0;
        e_dc = 1'b0;
        e_lp = 1'b0;
        if (r) begin
            in_g = 1'b0;
            long_m = 1'b0;
        end else if (!in_g) begin
            if (d) begin
                in_g = 1'b1; presses = 1; lvl = 1'b1; run = 1;
            end
        end else if (long_m) begin
            if (!d) begin
                in_g = 1'b0; long_m = 1'b0;
            end
        end else if (d == lvl) begin
            run++;
            if (lvl && run == LONG + 1) begin
                e_lp = 1'b1; long_m = 1'b1;
            end else if (!lvl && run == DC + 1) begin
                e_sc = 1'b1; in_g = 1'b0;
            end
        end else if (!d) begin
            if (DEN && presses == 1) begin
                lvl = 1'b0; run = 1;
            end else begin
                e_sc = presses == 1;
                e_dc = presses == 2;
                in_g = 1'b0;
            end
        end else begin
            presses = 2; lvl = 1'b1; run = 1;
        end
        e_held = in_g && (long_m || lvl);
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic d, input logic r);
        debounced = d;
        reset = r;
        @(posedge clk);
        model(d, r);
        #1;
        chk("single_click", single_click, e_sc);
        chk("double_click", double_click, e_dc);
        chk("long_press", long_press, e_lp);
        chk("held", held, e_held);
        chk("one_pulse", $countones({single_click, double_click, long_press}) <= 1, 1'b1);
    endtask

    task automatic hold(input logic d, input int n);
        for (int i = 0; i < n; i++) step(d, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        hold(1'b0, 50);
        hold(1'b1, 5);  hold(1'b0, 12);
        hold(1'b1, 3);  hold(1'b0, 4); hold(1'b1, 3); hold(1'b0, 12);
        hold(1'b1, 20); hold(1'b0, 5);
        hold(1'b1, 3);  hold(1'b0, 2); step(1'b0, 1'b1); hold(1'b0, 30);
        hold(1'b1, 3);  step(1'b1, 1'b1); hold(1'b1, 3); hold(1'b0, 12);
        hold(1'b1, LONG); hold(1'b0, DC); hold(1'b1, LONG + 1); hold(1'b0, 3);
        hold(1'b1, 2);  hold(1'b0, DC + 1); hold(1'b1, 2); hold(1'b0, DC + 2);
        for (int k = 0; k < 300; k++) begin
            automatic logic lv = 1'($urandom_range(0, 1));
            automatic int n = $urandom_range(1, LONG + 4);
            for (int i = 0; i < n; i++) step(lv, $urandom_range(0, 59) == 0);
        end
        hold(1'b0, 20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 16: PRESS1/PRESS2 dwell cycles that qualify a long press; legal range 2..255.
REQ-002 SHALL have parameter DCLICK_CYCLES, default 8: WAIT2 window for a second press; legal range 1..255.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port debounced, input, 1: clean button level from the debouncer; 1 = pressed; synchronous to clock.
REQ-006 SHALL have port single_click, output, 1: one-cycle pulse, one short press classified.
REQ-007 SHALL have port double_click, output, 1: one-cycle pulse, two short presses classified.
REQ-008 SHALL have port long_press, output, 1: one-cycle pulse, press held past LONG_CYCLES.
REQ-009 SHALL have port held, output, 1: level; 1 while state is PRESS1, PRESS2 or LONG_HELD.

Function
REQ-010 SHALL implement states IDLE, PRESS1, WAIT2, PRESS2 and LONG_HELD, plus a cycle counter cnt cleared on every state entry and incremented every cycle the state is unchanged.
REQ-011 SHALL size cnt to $clog2(max(LONG_CYCLES, DCLICK_CYCLES)+1) bits; cnt never wraps because each counted state exits on its limit.
REQ-012 IDLE SHALL go to PRESS1 on an edge sampling debounced=1, else stay.
REQ-013 PRESS1 SHALL go to LONG_HELD and pulse long_press on an edge sampling debounced=1 with cnt==LONG_CYCLES-1, i.e. after LONG_CYCLES+1 consecutive high samples.
REQ-014 PRESS1 SHALL go to WAIT2 on an edge sampling debounced=0 before that limit.
REQ-015 WAIT2 SHALL go to PRESS2 on an edge sampling debounced=1, or to IDLE with a single_click pulse on an edge sampling debounced=0 with cnt==DCLICK_CYCLES-1.
REQ-016 PRESS2 SHALL go to IDLE with a double_click pulse on an edge sampling debounced=0, or to LONG_HELD with a long_press pulse (no double_click) on the cnt==LONG_CYCLES-1 high sample.
REQ-017 LONG_HELD SHALL stay while debounced=1 and return to IDLE on debounced=0 with no click pulse.
REQ-018 All three pulse outputs SHALL be registered, high for exactly the one cycle following the deciding edge; at most one pulse is high in any cycle.
REQ-019 held SHALL be registered, from the next-state value, so it rises in the cycle after the IDLE->PRESS1 edge.

Reset
REQ-020 On an edge sampling reset=1, the block SHALL enter IDLE with cnt=0 and single_click=double_click=long_press=held=0; reset overrides every transition.
REQ-021 Reset asserted mid-sequence (PRESS1/WAIT2/PRESS2/LONG_HELD) SHALL discard the pending classification; no pulse follows reset release.
REQ-022 If debounced=1 on the first post-reset edge, the block SHALL treat it as a new press (IDLE->PRESS1).

Configuration
REQ-023 Macro BUTTON_EVENT_DCLICK_EN SHALL compile in double-click detection: WAIT2/PRESS2 exist and behave as REQ-014..REQ-016.
REQ-024 Without BUTTON_EVENT_DCLICK_EN: no WAIT2/PRESS2; PRESS1 SHALL go to IDLE with a single_click pulse on the release edge; double_click SHALL be tied 0; DCLICK_CYCLES is ignored.

Verification (defaults LONG_CYCLES=16, DCLICK_CYCLES=8)
REQ-025 Reset for 2 cycles, debounced=0 -> all outputs 0 for 50 cycles.
REQ-026 Macro on: debounced high 5 edges, then low -> after the 9th low edge single_click=1 for one cycle; double_click and long_press stay 0.
REQ-027 Macro on: high 3, low 4, high 3, then low -> double_click=1 one cycle after the second release edge; single_click never asserts.
REQ-028 High for 20 edges, then low -> long_press=1 for one cycle after the 17th high edge; held=1 from cycle 2 through the release edge; no click pulse follows.
REQ-029 Macro on: high 3, low 2, then reset for 1 cycle with debounced low -> IDLE, no pulses for 30 cycles.
REQ-030 Macro off: high 5, then low -> single_click=1 exactly one cycle after the release edge; double_click constant 0.
